// File: rtl/score_accumulator.sv
// score_accumulator: saturating Pac-Man score engine with ghost combo, high score and extra-life awards
module score_accumulator #(
    parameter int unsigned WIDTH      = 24,
    parameter int unsigned DOT_PTS    = 10,
    parameter int unsigned PELLET_PTS = 50,
    parameter int unsigned FRUIT_PTS  = 100,
    parameter int unsigned GHOST_BASE = 200,
    parameter int unsigned COMBO_MAX  = 3,
    parameter int unsigned LIFE_STEP  = 10000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             event_valid,
    input  logic [1:0]       event_type,
    input  logic             power_end,
    output logic [WIDTH-1:0] score,
    output logic [WIDTH-1:0] high_score,
    output logic [1:0]       combo,
    output logic             extra_life,
    output logic             saturated
);
    localparam int unsigned XW = (WIDTH > 31 ? WIDTH : 31) + 2;
    localparam logic [XW-1:0] LIM = XW'(1) << WIDTH;
    localparam logic [XW-1:0] MAXS = LIM - XW'(1);
    localparam logic [WIDTH:0] LIFE_INIT = (WIDTH+1)'(XW'(LIFE_STEP) > MAXS ? LIM : XW'(LIFE_STEP));
    logic [WIDTH-1:0] score_q, score_d, high_q, high_d, new_score;
    logic [WIDTH:0]   next_life_q, next_life_d;
    logic [1:0]       combo_q, combo_d;
    logic             life_q, life_d, sat_q, sat_d, ovf, award, ghost;
    logic [XW-1:0]    pts, sum, nl_inc;
    // Score the event, clamp on overflow, and advance combo / life threshold; next_life parks at 2^WIDTH once out of reach
    always_comb begin
        pts = event_type == 2'd0 ? XW'(DOT_PTS) : event_type == 2'd1 ? XW'(PELLET_PTS) :
              event_type == 2'd2 ? XW'(FRUIT_PTS) : XW'(GHOST_BASE) << combo_q;
        sum = XW'(score_q) + pts;
        ovf = sum > MAXS;
        new_score = ovf ? '1 : sum[WIDTH-1:0];
        award = LIFE_STEP != 0 && XW'(new_score) >= XW'(next_life_q);
        nl_inc = XW'(next_life_q) + XW'(LIFE_STEP);
        ghost = event_valid && event_type == 2'd3;
        score_d = clear ? '0 : event_valid ? new_score : score_q;
        high_d = !clear && event_valid && new_score > high_q ? new_score : high_q;
        combo_d = clear || power_end || (event_valid && event_type == 2'd1) ? 2'd0 :
                  ghost && combo_q != 2'(COMBO_MAX) ? combo_q + 2'd1 : combo_q;
        life_d = !clear && event_valid && award;
        sat_d = !clear && (sat_q || (event_valid && ovf));
        next_life_d = clear ? LIFE_INIT : life_d ? (WIDTH+1)'(nl_inc > LIM ? LIM : nl_inc) : next_life_q;
    end
    // State registers, all cleared asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            score_q     <= '0;
            high_q      <= '0;
            combo_q     <= 2'd0;
            life_q      <= 1'b0;
            sat_q       <= 1'b0;
            next_life_q <= LIFE_INIT;
        end else begin
            score_q     <= score_d;
            high_q      <= high_d;
            combo_q     <= combo_d;
            life_q      <= life_d;
            sat_q       <= sat_d;
            next_life_q <= next_life_d;
        end
    end
    assign score      = score_q;
    assign high_score = high_q;
    assign combo      = combo_q;
    assign extra_life = life_q;
    assign saturated  = sat_q;
endmodule

// File: tb/tb_score_accumulator.sv
// tb_score_accumulator: directed checks of the score engine at 24-bit and 8-bit widths
module tb_score_accumulator;
    logic clk = 1'b0, reset_n = 1'b0, clear = 1'b0, event_valid = 1'b0, power_end = 1'b0;
    logic [1:0] event_type = 2'd0;
    logic [23:0] score, high_score;
    logic [7:0] score8, high8;
    logic [1:0] combo, combo8;
    logic extra_life, saturated, life8, sat8;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    score_accumulator u24 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .event_valid(event_valid),
        .event_type(event_type), .power_end(power_end), .score(score),
        .high_score(high_score), .combo(combo), .extra_life(extra_life), .saturated(saturated)
    );

    score_accumulator #(.WIDTH(8), .LIFE_STEP(100)) u8 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .event_valid(event_valid),
        .event_type(event_type), .power_end(power_end), .score(score8),
        .high_score(high8), .combo(combo8), .extra_life(life8), .saturated(sat8)
    );

    task automatic step(input logic v, input logic [1:0] t, input logic pe, input logic clr);
        event_valid = v;
        event_type  = t;
        power_end   = pe;
        clear       = clr;
        @(posedge clk);
        #1;
        event_valid = 1'b0;
        power_end   = 1'b0;
        clear       = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        total++;
        if ({score, high_score, combo, extra_life, saturated} !== 52'd0) begin
            bad++; $display("FAIL reset24 got=%h want=0", {score, high_score, combo, extra_life, saturated});
        end
        total++;
        if ({score8, high8, combo8, life8, sat8} !== 20'd0) begin
            bad++; $display("FAIL reset8 got=%h want=0", {score8, high8, combo8, life8, sat8});
        end
    endtask

    task automatic test_basic;
        int exp_s[4] = '{10, 20, 30, 130};
        logic [1:0] typ[4] = '{2'd0, 2'd0, 2'd0, 2'd2};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, typ[i], 1'b0, 1'b0);
            total++;
            if (score !== 24'(exp_s[i]) || high_score !== 24'(exp_s[i]) || combo !== 2'd0) begin
                bad++; $display("FAIL basic[%0d] score=%0d high=%0d combo=%0d want=%0d/%0d/0", i, score, high_score, combo, exp_s[i], exp_s[i]);
            end
        end
    endtask

    task automatic test_combo;
        int exp_s[6] = '{180, 380, 780, 1580, 3180, 4780};
        logic [1:0] exp_c[6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        for (int i = 0; i < 6; i++) begin
            step(1'b1, i == 0 ? 2'd1 : 2'd3, 1'b0, 1'b0);
            total++;
            if (score !== 24'(exp_s[i]) || combo !== exp_c[i]) begin
                bad++; $display("FAIL combo[%0d] score=%0d combo=%0d want=%0d/%0d", i, score, combo, exp_s[i], exp_c[i]);
            end
        end
        step(1'b0, 2'd0, 1'b1, 1'b0);
        total++;
        if (combo !== 2'd0 || score !== 24'd4780 || high_score !== 24'd4780) begin
            bad++; $display("FAIL power_end combo=%0d score=%0d high=%0d want=0/4780/4780", combo, score, high_score);
        end
    endtask

    task automatic test_ghost_power_end;
        step(1'b0, 2'd0, 1'b0, 1'b1);
        step(1'b1, 2'd1, 1'b0, 1'b0);
        step(1'b1, 2'd3, 1'b0, 1'b0);
        step(1'b1, 2'd3, 1'b0, 1'b0);
        total++;
        if (score !== 24'd650 || combo !== 2'd2) begin
            bad++; $display("FAIL gpe_setup score=%0d combo=%0d want=650/2", score, combo);
        end
        step(1'b1, 2'd3, 1'b1, 1'b0);
        total++;
        if (score !== 24'd1450 || combo !== 2'd0) begin
            bad++; $display("FAIL gpe_same score=%0d combo=%0d want=1450/0", score, combo);
        end
        step(1'b1, 2'd3, 1'b0, 1'b0);
        total++;
        if (score !== 24'd1650 || combo !== 2'd1) begin
            bad++; $display("FAIL gpe_after score=%0d combo=%0d want=1650/1", score, combo);
        end
        step(1'b1, 2'd1, 1'b0, 1'b0);
        total++;
        if (score !== 24'd1700 || combo !== 2'd0) begin
            bad++; $display("FAIL pellet_reset score=%0d combo=%0d want=1700/0", score, combo);
        end
    endtask

    task automatic test_extra_life;
        step(1'b0, 2'd0, 1'b0, 1'b1);
        for (int i = 0; i < 108; i++) begin
            step(1'b1, i < 99 ? 2'd2 : 2'd0, 1'b0, 1'b0);
            total++;
            if (extra_life !== 1'b0) begin
                bad++; $display("FAIL life_early[%0d] got=%b want=0", i, extra_life);
            end
        end
        total++;
        if (score !== 24'd9990) begin
            bad++; $display("FAIL life_pre score=%0d want=9990", score);
        end
        step(1'b1, 2'd0, 1'b0, 1'b0);
        total++;
        if (score !== 24'd10000 || extra_life !== 1'b1) begin
            bad++; $display("FAIL life_cross score=%0d life=%b want=10000/1", score, extra_life);
        end
        step(1'b0, 2'd0, 1'b0, 1'b0);
        total++;
        if (extra_life !== 1'b0) begin
            bad++; $display("FAIL life_pulse got=%b want=0", extra_life);
        end
        step(1'b1, 2'd0, 1'b0, 1'b0);
        total++;
        if (score !== 24'd10010 || extra_life !== 1'b0) begin
            bad++; $display("FAIL life_next score=%0d life=%b want=10010/0", score, extra_life);
        end
        for (int i = 0; i < 107; i++) begin
            step(1'b1, i < 99 ? 2'd2 : 2'd0, 1'b0, 1'b0);
            total++;
            if (extra_life !== 1'b0) begin
                bad++; $display("FAIL life_mid[%0d] got=%b want=0", i, extra_life);
            end
        end
        step(1'b1, 2'd0, 1'b0, 1'b0);
        total++;
        if (score !== 24'd20000 || extra_life !== 1'b1) begin
            bad++; $display("FAIL life_cross2 score=%0d life=%b want=20000/1", score, extra_life);
        end
    endtask

    task automatic test_saturate;
        step(1'b0, 2'd0, 1'b0, 1'b1);
        step(1'b1, 2'd2, 1'b0, 1'b0);
        total++;
        if (score8 !== 8'd100 || life8 !== 1'b1) begin
            bad++; $display("FAIL s8_100 score=%0d life=%b want=100/1", score8, life8);
        end
        step(1'b1, 2'd2, 1'b0, 1'b0);
        total++;
        if (score8 !== 8'd200 || life8 !== 1'b1) begin
            bad++; $display("FAIL s8_200 score=%0d life=%b want=200/1", score8, life8);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 2'd0, 1'b0, 1'b0);
            total++;
            if (score8 !== 8'(210 + 10 * i) || life8 !== 1'b0 || sat8 !== 1'b0) begin
                bad++; $display("FAIL s8_dot[%0d] score=%0d life=%b sat=%b want=%0d/0/0", i, score8, life8, sat8, 210 + 10 * i);
            end
        end
        step(1'b1, 2'd2, 1'b0, 1'b0);
        total++;
        if (score8 !== 8'd255 || sat8 !== 1'b1 || life8 !== 1'b0 || high8 !== 8'd255) begin
            bad++; $display("FAIL s8_sat score=%0d sat=%b life=%b high=%0d want=255/1/0/255", score8, sat8, life8, high8);
        end
        step(1'b1, 2'd0, 1'b0, 1'b0);
        total++;
        if (score8 !== 8'd255 || sat8 !== 1'b1) begin
            bad++; $display("FAIL s8_hold score=%0d sat=%b want=255/1", score8, sat8);
        end
        step(1'b0, 2'd0, 1'b0, 1'b1);
        total++;
        if (score8 !== 8'd0 || sat8 !== 1'b0 || high8 !== 8'd255) begin
            bad++; $display("FAIL s8_clear score=%0d sat=%b high=%0d want=0/0/255", score8, sat8, high8);
        end
        step(1'b1, 2'd2, 1'b0, 1'b0);
        total++;
        if (score8 !== 8'd100 || life8 !== 1'b1) begin
            bad++; $display("FAIL s8_relife score=%0d life=%b want=100/1", score8, life8);
        end
    endtask

    task automatic test_clear_reset;
        step(1'b1, 2'd3, 1'b0, 1'b0);
        step(1'b1, 2'd0, 1'b0, 1'b1);
        total++;
        if (score !== 24'd0 || combo !== 2'd0 || high_score !== 24'd20000) begin
            bad++; $display("FAIL clear_dot score=%0d combo=%0d high=%0d want=0/0/20000", score, combo, high_score);
        end
        step(1'b1, 2'd3, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({score, high_score, combo, extra_life, saturated} !== 52'd0 || {score8, high8, combo8, life8, sat8} !== 20'd0) begin
            bad++; $display("FAIL async_reset got24=%h got8=%h want=0", {score, high_score, combo, extra_life, saturated}, {score8, high8, combo8, life8, sat8});
        end
        #3 reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_combo();
        test_ghost_power_end();
        test_extra_life();
        test_saturate();
        test_clear_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
